jt900h_memarb: RTL and testbench
================================

// Module: jt900h_memarb
// PURPOSE
//  Arbiter/sequencer for the single 16-bit RAM port of the JT900H core.
//  Shares the port between three requesters: micro-DMA, data load/store and
//  opcode prefetch.
//  Splits 8/16/32-bit data accesses, aligned or misaligned, into 16-bit bus
//  cycles and reassembles read data. Sits between jt900h_ctrl/jt900h_pc and
//  the external RAM.
// PARAMETERS
//  AW   24  address width
//  LAT  1   RAM read latency in cen cycles (1..3)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous, active-low reset
//  cen         in   1   clock enable; all state advances only when cen=1
//  dma_req     in   1   DMA request
//  dma_wr      in   1   DMA write (1) / read (0)
//  dma_addr    in   AW  DMA address (word access, bit0 ignored)
//  dma_din     in   16  DMA write data
//  dma_dout    out  16  DMA read data
//  dma_ack     out  1   DMA transaction done
//  data_req    in   1   data request
//  data_wr     in   1   data write (1) / read (0)
//  data_len    in   3   one-hot width: 001 byte, 010 word, 100 long
//  data_addr   in   AW  data byte address
//  data_din    in   32  write data, LSB-aligned
//  data_dout   out  32  read data, LSB-aligned, upper bits zero
//  data_ack    out  1   data transaction done
//  fetch_req   in   1   opcode prefetch request
//  fetch_addr  in   AW  prefetch address (bit0 ignored)
//  fetch_dout  out  16  fetched word
//  fetch_ack   out  1   fetch done
//  ram_addr    out  AW  RAM word address, bit0 always 0
//  ram_dout    in   16  RAM read data
//  ram_din     out  16  RAM write data
//  ram_we      out  2   byte write enables: [1] odd byte, [0] even byte
//  busy        out  1   transaction in progress
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, ram_we=0.
//  - Reset mid-transaction: aborts immediately. No retry. Written parts stay.
//  - States:
//    - IDLE: on cen, grant the highest pending request (dma > data > fetch)
//      and latch its address, length and write data -> ACCESS.
//    - ACCESS: drive ram_addr; for writes drive ram_we/ram_din for this one
//      cen cycle -> WAIT (read) or NEXT (write).
//    - WAIT: count LAT cen cycles; capture ram_dout -> NEXT.
//    - NEXT: last piece -> DONE; else step address by 2 -> ACCESS.
//    - DONE: pulse the granted *_ack for one clk with cen=1 -> IDLE.
//  - Grant is held until ack. Lower-priority requests wait.
//  - The requester keeps req and its inputs stable until ack. If req is
//    still high at IDLE, a new transaction starts.
//  - Bus cycles per access:
//    - byte: 1
//    - word: 1 if aligned, 2 if addr[0]=1
//    - long: 2 if aligned, 3 if addr[0]=1
//    - DMA and fetch: always 1
//  - Byte lanes: little-endian. Even byte = ram_dout[7:0] / ram_we[0].
//    Odd byte = [15:8] / ram_we[1].
//    - Byte write: ram_din={b,b}; ram_we=addr[0]?2'b10:2'b01.
//    - Misaligned first/last pieces enable only the valid lane.
//  - Read data is valid on *_dout in the ack cycle and held until the next
//    ack of that port.
//  - busy=1 from the grant to the ack, inclusive.
//  - cen=0 freezes state, counters and outputs; ram_we is held, not repeated.
//  - Address wraps modulo 2^AW.
//  - data_len not one-hot: treat as byte.
// TESTING
//  1. fetch_req @0x000100, RAM returns 0xABCD, LAT=1
//     -> ram_addr=0x000100; fetch_ack 3 cen later; fetch_dout=0xABCD.
//  2. data long read @0x001001
//     -> ram_addr 0x001000, 0x001002, 0x001004.
//     -> data_dout = {m[1004][7:0], m[1002], m[1000][15:8]}.
//  3. data byte write 0x55 @0x000203
//     -> one cycle: ram_addr=0x000202, ram_we=2'b10, ram_din=0x5555.
//  4. dma, data and fetch requested in the same cycle
//     -> acks in order dma, data, fetch; busy stays high, one IDLE cycle
//        between grants.
//  5. Long aligned write of 0x12345678 @0x000400 with cen toggling 1/0
//     -> writes 0x5678 @0x400, then 0x1234 @0x402.
//     -> each ram_we pulse lasts exactly one cen=1 cycle.
//  6. rst_n low during the 2nd cycle of a long write
//     -> ram_we=0 and all acks 0 immediately; after release, IDLE serves
//        a fresh request.

Source files
------------

// File: rtl/jt900h_memarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : jt900h_memarb                                                     |
// | Brief  : Three-way arbiter/sequencer for the JT900H 16-bit RAM port.       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module jt900h_memarb #(
    parameter int AW  = 24,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_addr,
    input  logic [15:0]   dma_din,
    output logic [15:0]   dma_dout,
    output logic          dma_ack,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [2:0]    data_len,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_din,
    output logic [31:0]   data_dout,
    output logic          data_ack,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic [15:0]   fetch_dout,
    output logic          fetch_ack,
    output logic [AW-1:0] ram_addr,
    input  logic [15:0]   ram_dout,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_we,
    output logic          busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] c_LEN_BYTE = 2'd0;
    localparam logic [1:0] c_LEN_WORD = 2'd1;
    localparam logic [1:0] c_LEN_LONG = 2'd2;
    localparam logic [1:0] c_G_DMA    = 2'd0;
    localparam logic [1:0] c_G_DATA   = 2'd1;
    localparam logic [1:0] c_G_FETCH  = 2'd2;
    localparam logic [1:0] c_LAT_LAST = 2'(LAT - 1);

    state_t        r_state;
    logic [1:0]    r_gnt, r_len, r_last, r_piece, r_lat;
    logic          r_wr, r_a0;
    logic [47:0]   r_wbuf, r_rbuf;
    logic [5:0]    r_bm;
    logic [AW-1:0] r_ram_addr;
    logic [15:0]   r_ram_din, r_dma_dout, r_fetch_dout;
    logic [1:0]    r_ram_we;
    logic [31:0]   r_data_dout;
    logic          r_dma_ack, r_data_ack, r_fetch_ack, r_busy;

    logic          w_sel_dma, w_sel_data, w_any, w_wr, w_a0, w_others;
    logic [1:0]    w_gnt, w_len, w_last, w_np;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_din, w_dmask, w_rmask;
    logic [3:0]    w_bm4;
    logic [5:0]    w_bm;
    logic [47:0]   w_wbuf;

    assign w_sel_dma  = dma_req;
    assign w_sel_data = !dma_req && data_req;
    assign w_any      = dma_req || data_req || fetch_req;
    assign w_gnt      = w_sel_dma ? c_G_DMA : (w_sel_data ? c_G_DATA : c_G_FETCH);
    assign w_addr     = w_sel_dma ? dma_addr : (w_sel_data ? data_addr : fetch_addr);
    assign w_wr       = w_sel_dma ? dma_wr : (w_sel_data && data_wr);
    assign w_din      = w_sel_dma ? {16'h0000, dma_din} : data_din;
    // DMA and fetch are always word-aligned, so only data accesses may split
    assign w_a0       = w_sel_data && w_addr[0];
    assign w_np       = r_piece + 2'd1;

    always_comb begin
        w_len = c_LEN_WORD;
        if (w_sel_data) begin
            case (data_len)
                3'b010:  w_len = c_LEN_WORD;
                3'b100:  w_len = c_LEN_LONG;
                default: w_len = c_LEN_BYTE;
            endcase
        end
        w_dmask = 32'h0000_00ff;
        w_bm4   = 4'b0001;
        w_last  = 2'd0;
        case (w_len)
            c_LEN_WORD: begin
                w_dmask = 32'h0000_ffff;
                w_bm4   = 4'b0011;
                w_last  = {1'b0, w_a0};
            end
            c_LEN_LONG: begin
                w_dmask = 32'hffff_ffff;
                w_bm4   = 4'b1111;
                w_last  = 2'd1 + {1'b0, w_a0};
            end
            default: ;
        endcase
    end

    // Write data and byte enables laid out across up to three bus words
    assign w_wbuf = (w_len == c_LEN_BYTE) ? {32'h0, w_din[7:0], w_din[7:0]}
                                          : ({16'h0000, w_din & w_dmask} << {w_a0, 3'b000});
    assign w_bm   = {2'b00, w_bm4} << w_a0;

    always_comb begin
        case (r_len)
            c_LEN_WORD: w_rmask = 32'h0000_ffff;
            c_LEN_LONG: w_rmask = 32'hffff_ffff;
            default:    w_rmask = 32'h0000_00ff;
        endcase
    end

    assign w_others = (dma_req   && r_gnt != c_G_DMA)  ||
                      (data_req  && r_gnt != c_G_DATA) ||
                      (fetch_req && r_gnt != c_G_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= 2'd0;
            r_len        <= 2'd0;
            r_last       <= 2'd0;
            r_piece      <= 2'd0;
            r_lat        <= 2'd0;
            r_wr         <= 1'b0;
            r_a0         <= 1'b0;
            r_wbuf       <= '0;
            r_rbuf       <= '0;
            r_bm         <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_we     <= 2'b00;
            r_dma_dout   <= '0;
            r_fetch_dout <= '0;
            r_data_dout  <= '0;
            r_dma_ack    <= 1'b0;
            r_data_ack   <= 1'b0;
            r_fetch_ack  <= 1'b0;
            r_busy       <= 1'b0;
        end else if (cen) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_gnt;
                        r_wr       <= w_wr;
                        r_len      <= w_len;
                        r_a0       <= w_a0;
                        r_last     <= w_last;
                        r_wbuf     <= w_wbuf;
                        r_bm       <= w_bm;
                        r_rbuf     <= '0;
                        r_piece    <= 2'd0;
                        r_ram_addr <= {w_addr[AW-1:1], 1'b0};
                        r_ram_din  <= w_wbuf[15:0];
                        r_ram_we   <= w_wr ? w_bm[1:0] : 2'b00;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCESS;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    r_ram_we <= 2'b00;
                    r_lat    <= 2'd0;
                    r_state  <= r_wr ? S_NEXT : S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat == c_LAT_LAST) begin
                        r_rbuf[{r_piece, 4'b0000} +: 16] <= ram_dout;
                        r_state <= S_NEXT;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_NEXT: begin
                    if (r_piece == r_last) begin
                        r_state <= S_DONE;
                        case (r_gnt)
                            c_G_DMA: begin
                                r_dma_ack <= 1'b1;
                                if (!r_wr) r_dma_dout <= r_rbuf[15:0];
                            end
                            c_G_DATA: begin
                                r_data_ack <= 1'b1;
                                if (!r_wr) r_data_dout <= 32'(r_rbuf >> {r_a0, 3'b000}) & w_rmask;
                            end
                            default: begin
                                r_fetch_ack  <= 1'b1;
                                r_fetch_dout <= r_rbuf[15:0];
                            end
                        endcase
                    end else begin
                        r_piece    <= w_np;
                        r_ram_addr <= r_ram_addr + AW'(2);
                        r_ram_din  <= 16'(r_wbuf >> {w_np, 4'b0000});
                        r_ram_we   <= r_wr ? 2'(r_bm >> {w_np, 1'b0}) : 2'b00;
                        r_state    <= S_ACCESS;
                    end
                end
                S_DONE: begin
                    r_dma_ack   <= 1'b0;
                    r_data_ack  <= 1'b0;
                    r_fetch_ack <= 1'b0;
                    // Keep busy asserted across the IDLE gap when another requester waits
                    r_busy      <= w_others;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dma_dout   = r_dma_dout;
    assign dma_ack    = r_dma_ack;
    assign data_dout  = r_data_dout;
    assign data_ack   = r_data_ack;
    assign fetch_dout = r_fetch_dout;
    assign fetch_ack  = r_fetch_ack;
    assign ram_addr   = r_ram_addr;
    assign ram_din    = r_ram_din;
    assign ram_we     = r_ram_we;
    assign busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_jt900h_memarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_jt900h_memarb                                                  |
// | Brief  : Directed self-checking bench for jt900h_memarb with a RAM model.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_jt900h_memarb;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b1;
    logic          dma_req = 1'b0, dma_wr = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [15:0]   dma_din = '0, dma_dout;
    logic          dma_ack;
    logic          data_req = 1'b0, data_wr = 1'b0;
    logic [2:0]    data_len = 3'b001;
    logic [AW-1:0] data_addr = '0;
    logic [31:0]   data_din = '0, data_dout;
    logic          data_ack;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [15:0]   fetch_dout;
    logic          fetch_ack;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_dout, ram_din;
    logic [1:0]    ram_we;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]   mem [0:4095];
    logic [AW-1:0] wl_addr[$];
    logic [15:0]   wl_din[$];
    logic [1:0]    wl_we[$];

    jt900h_memarb #(.AW(AW), .LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ack(dma_ack),
        .data_req(data_req), .data_wr(data_wr), .data_len(data_len), .data_addr(data_addr),
        .data_din(data_din), .data_dout(data_dout), .data_ack(data_ack),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_dout(fetch_dout),
        .fetch_ack(fetch_ack),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_we(ram_we),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr[12:1]];

    always @(posedge clk) begin
        if (rst_n && cen && ram_we != 2'b00) begin
            wl_addr.push_back(ram_addr);
            wl_din.push_back(ram_din);
            wl_we.push_back(ram_we);
        end
    end

    // which: 0 dma, 1 data, 2 fetch; cyc = -1 on timeout
    task automatic wait_ack(input int which, output int cyc);
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            cyc++;
            if ((which == 0 && dma_ack) || (which == 1 && data_ack) || (which == 2 && fetch_ack))
                return;
        end
        cyc = -1;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ram_we !== 2'b00) begin n_fail++; $display("FAIL reset_we got=%b exp=00", ram_we); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if ({dma_ack, data_ack, fetch_ack} !== 3'b000) begin
            n_fail++; $display("FAIL reset_acks got=%b exp=000", {dma_ack, data_ack, fetch_ack}); end
        n_tests++; if (ram_addr !== '0 || data_dout !== '0) begin
            n_fail++; $display("FAIL reset_outs addr=%h dout=%h exp=0", ram_addr, data_dout); end
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_fetch();
        int cyc;
        fetch_addr = 24'h000100;
        fetch_req  = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ram_addr !== 24'h000100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fetch_addr got=%h busy=%b exp=000100 busy=1", ram_addr, busy); end
        wait_ack(2, cyc);
        fetch_req = 1'b0;
        n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL fetch_latency got=%0d exp=3", cyc); end
        n_tests++; if (fetch_dout !== 16'hABCD) begin
            n_fail++; $display("FAIL fetch_dout got=%h exp=abcd", fetch_dout); end
        settle();
    endtask

    task automatic test_long_read_misaligned();
        logic [AW-1:0] seen[$];
        logic [AW-1:0] last;
        logic          got;
        got  = 1'b0;
        last = ram_addr;
        data_req = 1'b1; data_wr = 1'b0; data_len = 3'b100; data_addr = 24'h001001;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (ram_addr !== last) begin seen.push_back(ram_addr); last = ram_addr; end
            got = data_ack;
        end
        data_req = 1'b0;
        n_tests++; if (!got) begin n_fail++; $display("FAIL lread_ack got=0 exp=1"); end
        n_tests++; if (seen.size() != 3) begin
            n_fail++; $display("FAIL lread_ncycles got=%0d exp=3", seen.size()); end
        else begin
            n_tests++; if (seen[0] !== 24'h001000 || seen[1] !== 24'h001002 || seen[2] !== 24'h001004) begin
                n_fail++; $display("FAIL lread_addrs got=%h %h %h exp=001000 001002 001004",
                                   seen[0], seen[1], seen[2]); end
        end
        n_tests++; if (data_dout !== 32'h66334411) begin
            n_fail++; $display("FAIL lread_dout got=%h exp=66334411", data_dout); end
        settle();
    endtask

    task automatic test_byte_read_odd();
        int cyc;
        data_req = 1'b1; data_wr = 1'b0; data_len = 3'b001; data_addr = 24'h001003;
        wait_ack(1, cyc);
        data_req = 1'b0;
        n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL bread_latency got=%0d exp=4", cyc); end
        n_tests++; if (data_dout !== 32'h00000033) begin
            n_fail++; $display("FAIL bread_dout got=%h exp=00000033", data_dout); end
        settle();
    endtask

    task automatic test_byte_write();
        int cyc, base;
        base = wl_addr.size();
        data_req = 1'b1; data_wr = 1'b1; data_len = 3'b001; data_addr = 24'h000203;
        data_din = 32'hFFFFFF55;
        wait_ack(1, cyc);
        data_req = 1'b0;
        n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL bwrite_latency got=%0d exp=3", cyc); end
        n_tests++; if (wl_addr.size() != base + 1) begin
            n_fail++; $display("FAIL bwrite_count got=%0d exp=1", wl_addr.size() - base); end
        else begin
            n_tests++; if (wl_addr[base] !== 24'h000202 || wl_we[base] !== 2'b10 || wl_din[base] !== 16'h5555) begin
                n_fail++; $display("FAIL bwrite_bus addr=%h we=%b din=%h exp=000202 10 5555",
                                   wl_addr[base], wl_we[base], wl_din[base]); end
        end
        settle();
    endtask

    task automatic test_long_write_cen();
        int  base;
        logic got;
        got  = 1'b0;
        base = wl_addr.size();
        data_req = 1'b1; data_wr = 1'b1; data_len = 3'b100; data_addr = 24'h000400;
        data_din = 32'h12345678;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            cen = ~cen;
            got = data_ack;
        end
        data_req = 1'b0;
        cen = 1'b1;
        n_tests++; if (!got) begin n_fail++; $display("FAIL lwcen_ack got=0 exp=1"); end
        n_tests++; if (wl_addr.size() != base + 2) begin
            n_fail++; $display("FAIL lwcen_pulses got=%0d exp=2", wl_addr.size() - base); end
        else begin
            n_tests++; if (wl_addr[base] !== 24'h000400 || wl_din[base] !== 16'h5678 || wl_we[base] !== 2'b11) begin
                n_fail++; $display("FAIL lwcen_w0 addr=%h din=%h we=%b exp=000400 5678 11",
                                   wl_addr[base], wl_din[base], wl_we[base]); end
            n_tests++; if (wl_addr[base+1] !== 24'h000402 || wl_din[base+1] !== 16'h1234 || wl_we[base+1] !== 2'b11) begin
                n_fail++; $display("FAIL lwcen_w1 addr=%h din=%h we=%b exp=000402 1234 11",
                                   wl_addr[base+1], wl_din[base+1], wl_we[base+1]); end
        end
        settle();
    endtask

    task automatic test_long_write_misaligned();
        int cyc, base;
        logic [AW-1:0] ea [3];
        logic [15:0]   ed [3];
        logic [1:0]    ew [3];
        ea = '{24'h000500, 24'h000502, 24'h000504};
        ed = '{16'hDD00, 16'hBBCC, 16'h00AA};
        ew = '{2'b10, 2'b11, 2'b01};
        base = wl_addr.size();
        data_req = 1'b1; data_wr = 1'b1; data_len = 3'b100; data_addr = 24'h000501;
        data_din = 32'hAABBCCDD;
        wait_ack(1, cyc);
        data_req = 1'b0;
        n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL lwmis_latency got=%0d exp=7", cyc); end
        n_tests++; if (wl_addr.size() != base + 3) begin
            n_fail++; $display("FAIL lwmis_count got=%0d exp=3", wl_addr.size() - base); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (wl_addr[base+k] !== ea[k] || wl_din[base+k] !== ed[k] || wl_we[base+k] !== ew[k]) begin
                    n_fail++;
                    $display("FAIL lwmis_piece%0d addr=%h din=%h we=%b exp=%h %h %b", k,
                             wl_addr[base+k], wl_din[base+k], wl_we[base+k], ea[k], ed[k], ew[k]);
                end
            end
        end
        settle();
    endtask

    task automatic test_priority();
        int a_dma, a_data, a_fetch, busy_low;
        a_dma = -1; a_data = -1; a_fetch = -1; busy_low = 0;
        dma_addr = 24'h000300; dma_wr = 1'b0; dma_req = 1'b1;
        data_addr = 24'h000304; data_wr = 1'b0; data_len = 3'b010; data_req = 1'b1;
        fetch_addr = 24'h000306; fetch_req = 1'b1;
        for (int c = 1; c <= 40 && a_fetch < 0; c++) begin
            @(posedge clk); #1;
            if (!busy) busy_low++;
            if (dma_ack)   begin a_dma = c;   dma_req = 1'b0;   end
            if (data_ack)  begin a_data = c;  data_req = 1'b0;  end
            if (fetch_ack) begin a_fetch = c; fetch_req = 1'b0; end
        end
        dma_req = 1'b0; data_req = 1'b0; fetch_req = 1'b0;
        n_tests++; if (a_dma != 4 || a_data != 9 || a_fetch != 14) begin
            n_fail++; $display("FAIL prio_order got=%0d,%0d,%0d exp=4,9,14", a_dma, a_data, a_fetch); end
        n_tests++; if (busy_low != 0) begin
            n_fail++; $display("FAIL prio_busy low_cycles got=%0d exp=0", busy_low); end
        n_tests++; if (dma_dout !== 16'hD0D0 || data_dout !== 32'h0000DA7A || fetch_dout !== 16'hFE7C) begin
            n_fail++; $display("FAIL prio_data got=%h %h %h exp=d0d0 0000da7a fe7c",
                               dma_dout, data_dout, fetch_dout); end
        settle();
    endtask

    task automatic test_reset_midwrite();
        int cyc, base;
        base = wl_addr.size();
        data_req = 1'b1; data_wr = 1'b1; data_len = 3'b100; data_addr = 24'h000600;
        data_din = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ram_we !== 2'b11 || ram_addr !== 24'h000602) begin
            n_fail++; $display("FAIL rstmid_pre we=%b addr=%h exp=11 000602", ram_we, ram_addr); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (ram_we !== 2'b00 || {dma_ack, data_ack, fetch_ack} !== 3'b000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abort we=%b acks=%b busy=%b exp=00 000 0",
                               ram_we, {dma_ack, data_ack, fetch_ack}, busy); end
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_tests++; if (wl_addr.size() != base + 1 || wl_din[base] !== 16'hF00D) begin
            n_fail++; $display("FAIL rstmid_written count=%0d exp=1 first=F00D", wl_addr.size() - base); end
        fetch_addr = 24'h000100; fetch_req = 1'b1;
        wait_ack(2, cyc);
        fetch_req = 1'b0;
        n_tests++; if (cyc != 4 || fetch_dout !== 16'hABCD) begin
            n_fail++; $display("FAIL rstmid_fresh cyc=%0d dout=%h exp=4 abcd", cyc, fetch_dout); end
        settle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h080] = 16'hABCD;
        mem[12'h800] = 16'h1122;
        mem[12'h801] = 16'h3344;
        mem[12'h802] = 16'h5566;
        mem[12'h180] = 16'hD0D0;
        mem[12'h182] = 16'hDA7A;
        mem[12'h183] = 16'hFE7C;

        test_reset();
        test_fetch();
        test_long_read_misaligned();
        test_byte_read_odd();
        test_byte_write();
        test_long_write_cen();
        test_long_write_misaligned();
        test_priority();
        test_reset_midwrite();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
